// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter/sequencer loading one requester's data into a shared WIDTH-bit register.
// Build option: define DFF_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module dff_write_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic [WIDTH-1:0]       q,
    output logic [IDX_W-1:0]       q_owner,
    output logic                   busy,
    output logic [7:0]             wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic               load;
    logic [WIDTH-1:0]   sel_data;

`ifdef DFF_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    logic [IDX_W-1:0]   rr_ptr;
    assign search_start = rr_ptr;
`endif

    // N_REQ is a power of two, so the IDX_W-bit add wraps modulo N_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = search_start + IDX_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    state_next = DONE;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= '0;
            q        <= '0;
            q_owner  <= '0;
            wr_count <= '0;
`ifndef DFF_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && |req) begin
                sel <= winner;
            end
            if (load) begin
                q        <= sel_data;
                q_owner  <= sel;
                wr_count <= wr_count + 8'd1;
`ifndef DFF_ARB_FIXED_PRIO_EN
                rr_ptr   <= sel + IDX_W'(1);
`endif
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (state == GRANT) begin
            gnt[sel] = 1'b1;
        end
    end

    assign ack  = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed self-checking bench for dff_write_arbiter (N_REQ=4, WIDTH=8).
module tb_dff_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  q;
    logic [1:0]  q_owner;
    logic        busy;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;
    int exp_idx;

    dff_write_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .q_owner  (q_owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset held with all requests pending
        rst   = 1'b0;
        req   = 4'b1111;
        wdata = 32'h13121110;
        tick();
        tick();
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_ack",   32'(ack), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_q",     32'(q), 32'h0);
        chk("rst_cnt",   32'(wr_count), 32'h0);
        chk("rst_owner", 32'(q_owner), 32'h0);
        rst = 1'b1;
        tick();
        chk("first_gnt",  32'(gnt), 32'h1);
        chk("first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("abort0_ack", 32'(ack), 32'h0);
        chk("abort0_gnt", 32'(gnt), 32'h0);
        chk("abort0_cnt", 32'(wr_count), 32'h0);
        chk("abort0_q",   32'(q), 32'h0);

        // Single write from requester 2
        req   = 4'b0100;
        wdata = 32'h33A5_2211;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_ack_early", 32'(ack), 32'h0);
        tick();
        chk("single_ack",   32'(ack), 32'h1);
        chk("single_gnt0",  32'(gnt), 32'h0);
        chk("single_q",     32'(q), 32'hA5);
        chk("single_owner", 32'(q_owner), 32'h2);
        chk("single_cnt",   32'(wr_count), 32'h1);
        chk("single_busy",  32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("single_idle_ack",  32'(ack), 32'h0);
        chk("single_idle_busy", 32'(busy), 32'h0);

        // Round-robin from a fresh reset
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        wdata = 32'h13121110;
        req   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = k;
`endif
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1) << exp_idx);
            chk("rr_noack", 32'(ack), 32'h0);
            tick();
            chk("rr_ack",   32'(ack), 32'h1);
            chk("rr_q",     32'(q), 32'h10 + 32'(exp_idx));
            chk("rr_owner", 32'(q_owner), 32'(exp_idx));
            chk("rr_cnt",   32'(wr_count), 32'(k + 1));
            tick();
            chk("rr_idle", 32'(busy), 32'h0);
        end
        req = 4'b0000;

`ifndef DFF_ARB_FIXED_PRIO_EN
        // Abort by requester 1; rr_ptr must stay at 0 so 1 wins over 3 again
        req = 4'b0010;
        tick();
        chk("abort_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        chk("abort_ack",  32'(ack), 32'h0);
        chk("abort_gnt0", 32'(gnt), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_q",    32'(q), 32'h13);
        chk("abort_cnt",  32'(wr_count), 32'h4);
        req = 4'b1010;
        tick();
        chk("after_abort_gnt", 32'(gnt), 32'h2);
        tick();
        chk("after_abort_ack", 32'(ack), 32'h1);
        chk("after_abort_q",   32'(q), 32'h11);
        chk("after_abort_cnt", 32'(wr_count), 32'h5);
        req = 4'b0000;
        tick();
`endif

        // Reset on the GRANT-exit edge
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 4'b0001;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'h1);
        rst = 1'b0;
        tick();
        chk("midrst_q",    32'(q), 32'h0);
        chk("midrst_ack",  32'(ack), 32'h0);
        chk("midrst_gnt0", 32'(gnt), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cnt",  32'(wr_count), 32'h0);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk("midrst_after_ack", 32'(ack), 32'h0);

        // 256 writes from requester 0: counter wraps to 0
        for (int k = 0; k < 256; k++) begin
            wdata = {24'h0, 8'(k) ^ 8'h5A};
            req   = 4'b0001;
            tick();
            tick();
            if (k == 254) begin
                chk("wrap_cnt_255", 32'(wr_count), 32'hFF);
            end
            tick();
        end
        req = 4'b0000;
        chk("wrap_cnt",   32'(wr_count), 32'h0);
        chk("wrap_q",     32'(q), 32'hA5);
        chk("wrap_owner", 32'(q_owner), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
